// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encoding and widths for the serializer
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Matches the downstream detector's counter width
    localparam int   COUNT_W          = 10;
    localparam logic DEFAULT_IDLE_BIT = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel word handshake plus serial output bundle
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;

    modport master (output din, output din_valid, input din_ready, input x, input x_valid);
    modport slave  (input din, input din_valid, output din_ready, output x, output x_valid);
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with optional inter-word idle gap
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter int   GAP       = 0,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    piso_serializer_if.slave    io_s,
    output logic                o_busy,
    output logic [COUNT_W-1:0]  o_words_sent
);

    localparam int                BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0]  LAST_IDX = BIT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LAST = 4'(GAP - 1);

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_shift, w_shift_nxt;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0]           r_gap_cnt, w_gap_cnt_nxt;
    logic                 r_x, w_x_nxt;
    logic                 r_x_valid, w_x_valid_nxt;
    logic [COUNT_W-1:0]   r_words, w_words_nxt;
    logic                 w_last;
    logic                 w_ready;
    logic                 w_accept;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign w_last   = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_IDX);
    // Ready never looks at din_valid so upstream sees no combinational loop
    assign w_ready  = !i_rst && ((r_state == ST_IDLE) || (w_last && (GAP == 0)));
    assign w_accept = w_ready && io_s.din_valid;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_x_nxt       = IDLE_BIT;
        w_x_valid_nxt = 1'b0;
        w_words_nxt   = r_words;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = ST_SHIFT;
                    w_x_nxt       = head_bit(io_s.din);
                    w_x_valid_nxt = 1'b1;
                    w_shift_nxt   = drop_head(io_s.din);
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_x_nxt       = head_bit(r_shift);
                    w_x_valid_nxt = 1'b1;
                    w_shift_nxt   = drop_head(r_shift);
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end else begin
                    w_words_nxt   = r_words + 1'b1;
                    w_bit_cnt_nxt = '0;
                    if (GAP != 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = '0;
                    end else if (w_accept) begin
                        w_x_nxt       = head_bit(io_s.din);
                        w_x_valid_nxt = 1'b1;
                        w_shift_nxt   = drop_head(io_s.din);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_words   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_x_valid_nxt;
            r_words   <= w_words_nxt;
        end
    end

    assign io_s.din_ready = w_ready;
    assign io_s.x         = r_x;
    assign io_s.x_valid   = r_x_valid;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_words_sent   = r_words;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized and directed bench against a cycle-timeline model
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    localparam int W    = 8;
    localparam int MAXC = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if_a ();
    piso_serializer_if #(.WIDTH(W)) if_b ();

    logic               busy_a, busy_b;
    logic [COUNT_W-1:0] words_a, words_b;

    // Unit A: MSB first, no gap.  Unit B: LSB first, two idle cycles between words.
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .io_s(if_a), .o_busy(busy_a), .o_words_sent(words_a));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(2), .IDLE_BIT(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .io_s(if_b), .o_busy(busy_b), .o_words_sent(words_b));

    logic [W-1:0] drv_din [2];
    logic         drv_v   [2];
    assign if_a.din       = drv_din[0];
    assign if_a.din_valid = drv_v[0];
    assign if_b.din       = drv_din[1];
    assign if_b.din_valid = drv_v[1];

    logic o_rdy [2], o_x [2], o_xv [2], o_bsy [2];
    logic [COUNT_W-1:0] o_w [2];
    assign o_rdy[0] = if_a.din_ready;  assign o_rdy[1] = if_b.din_ready;
    assign o_x[0]   = if_a.x;          assign o_x[1]   = if_b.x;
    assign o_xv[0]  = if_a.x_valid;    assign o_xv[1]  = if_b.x_valid;
    assign o_bsy[0] = busy_a;          assign o_bsy[1] = busy_b;
    assign o_w[0]   = words_a;         assign o_w[1]   = words_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference timeline: expected serial line per cycle, plus word-completion cycles
    logic exp_x  [2][MAXC];
    logic exp_v  [2][MAXC];
    int   last_q [2][$];
    int   words_m [2];
    int   next_rdy [2];
    int   busy_end [2];
    logic acc [2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic bit_at(input int d, input logic [W-1:0] w, input int k);
        return (d == 0) ? w[W-1-k] : w[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        for (int t = cyc; t < cyc + 40 && t < MAXC; t++) begin
            exp_x[d][t] = 1'b1;
            exp_v[d][t] = 1'b0;
        end
        last_q[d].delete();
        words_m[d]  = 0;
        next_rdy[d] = 0;
        busy_end[d] = -1;
    endtask

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic er, eb;
            if (rst) model_reset(d);
            while (last_q[d].size() > 0 && last_q[d][0] < cyc) begin
                void'(last_q[d].pop_front());
                words_m[d] = (words_m[d] + 1) % 1024;
            end
            er = !rst && (cyc >= next_rdy[d]);
            eb = !rst && (cyc <= busy_end[d]);
            chk($sformatf("din_ready[%0d]", d), 32'(o_rdy[d]), 32'(er));
            chk($sformatf("x[%0d]", d),         32'(o_x[d]),   32'(exp_x[d][cyc]));
            chk($sformatf("x_valid[%0d]", d),   32'(o_xv[d]),  32'(exp_v[d][cyc]));
            chk($sformatf("busy[%0d]", d),      32'(o_bsy[d]), 32'(eb));
            chk($sformatf("words[%0d]", d),     32'(o_w[d]),   32'(words_m[d]));
            acc[d] = er && drv_v[d];
            if (acc[d]) begin
                int l;
                for (int k = 0; k < W; k++) begin
                    exp_x[d][cyc + 1 + k] = bit_at(d, drv_din[d], k);
                    exp_v[d][cyc + 1 + k] = 1'b1;
                end
                l = cyc + W;
                last_q[d].push_back(l);
                busy_end[d] = l + gap_of(d);
                next_rdy[d] = (gap_of(d) == 0) ? l : l + gap_of(d) + 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async_x[%0d]", d),  32'(o_x[d]),  32'd1);
            chk($sformatf("async_xv[%0d]", d), 32'(o_xv[d]), 32'd0);
            chk($sformatf("async_w[%0d]", d),  32'(o_w[d]),  32'd0);
        end
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    task automatic send(input int d, input logic [W-1:0] w);
        int guard;
        drv_din[d] = w;
        drv_v[d]   = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!acc[d] && guard < 100);
        chk($sformatf("accept_timeout[%0d]", d), 32'(acc[d]), 32'd1);
    endtask

    task automatic idle(input int n);
        drv_v[0] = 1'b0;
        drv_v[1] = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #((MAXC + 2000) * 10);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int accepted, guard;
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < MAXC; t++) begin
                exp_x[d][t] = 1'b1;
                exp_v[d][t] = 1'b0;
            end
            drv_din[d] = '0;
            drv_v[d]   = 1'b0;
            acc[d]     = 1'b0;
            model_reset(d);
        end

        // Reset held for three clocks, then release
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        step();

        // Single word, then back-to-back pair on the no-gap unit
        send(0, 8'hA5);
        idle(10);
        send(0, 8'hA5);
        send(0, 8'h3C);
        idle(12);

        // Gap and backpressure on the LSB-first unit
        send(1, 8'h01);
        send(1, 8'h80);
        idle(14);

        // Reset mid-word after three bits have appeared
        send(0, 8'h55);
        drv_v[0] = 1'b0;
        step();
        step();
        pulse_reset(2);
        send(0, 8'h55);
        idle(12);

        // Counter wrap: 1024 all-ones words from a fresh reset
        pulse_reset(1);
        step();
        drv_din[0] = 8'hFF;
        drv_v[0]   = 1'b1;
        accepted   = 0;
        guard      = 0;
        while (accepted < 1024 && guard < 9000) begin
            step();
            if (acc[0]) accepted++;
            guard++;
        end
        chk("wrap_accepts", 32'(accepted), 32'd1024);
        idle(W + 2);
        chk("wrap_zero", 32'(words_a), 32'd0);

        // Randomized traffic on both units with occasional resets
        for (int i = 0; i < 2500; i++) begin
            for (int d = 0; d < 2; d++) begin
                drv_din[d] = W'($urandom);
                drv_v[d]   = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 399) == 0) pulse_reset($urandom_range(1, 2));
            else step();
        end
        idle(16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
